// File: rtl/clk_div_monitor.sv
// Receive-side monitor for a divided clock: synchronises it, measures half and
// full periods in i_clk cycles and reports lock / error status.
module clk_div_monitor #(
    parameter int P_CLK_DIV_CNT = 2,
    parameter int P_LOCK_CNT    = 4,
    parameter int P_TOL         = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_clk_div,
    output logic        o_edge,
    output logic [15:0] o_period,
    output logic        o_period_valid,
    output logic        o_locked,
    output logic        o_err
);

    localparam int EXP = P_CLK_DIV_CNT / 2;
    localparam int HI  = EXP + P_TOL;
    localparam int LO  = (EXP > P_TOL) ? (EXP - P_TOL) : 1;

    localparam logic [16:0] HL_LO  = 17'(LO);
    localparam logic [16:0] HL_HI  = 17'(HI);
    localparam logic [15:0] TMO    = 16'(HI);
    localparam logic [7:0]  LOCK_N = 8'(P_LOCK_CNT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACQ    = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_LOCKED = 2'd3;

    logic        s1_q, s2_q, s3_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [7:0]  good_q, good_d;
    logic        seen_q, seen_d;
    logic        edge_q, edge_d;
    logic [15:0] period_q, period_d;
    logic        pval_q, pval_d;
    logic        err_q, err_d;

    logic        edge_w, rise_w, active, hsat, psat, good_hl, tmo;
    logic [16:0] hl;

    always_comb begin
        edge_w  = s2_q ^ s3_q;
        rise_w  = s2_q & ~s3_q;
        active  = i_en && (state_q != S_IDLE);
        hsat    = &hcnt_q;
        psat    = &pcnt_q;
        hl      = {1'b0, hcnt_q} + 17'd1;
        // a saturated half counter can never be a good half
        good_hl = !hsat && (hl >= HL_LO) && (hl <= HL_HI);
        tmo     = ((state_q == S_CHECK) || (state_q == S_LOCKED))
                  && !edge_w && (hcnt_q == TMO);

        state_d  = state_q;
        hcnt_d   = hcnt_q;
        pcnt_d   = pcnt_q;
        good_d   = good_q;
        seen_d   = seen_q;
        period_d = period_q;
        edge_d   = 1'b0;
        pval_d   = 1'b0;
        err_d    = 1'b0;

        if (!active) begin
            hcnt_d  = '0;
            pcnt_d  = '0;
            good_d  = '0;
            seen_d  = 1'b0;
            state_d = i_en ? S_ACQ : S_IDLE;
        end else begin
            hcnt_d = edge_w ? 16'd0 : (hsat ? hcnt_q : hcnt_q + 16'd1);
            pcnt_d = rise_w ? 16'd0 : (psat ? pcnt_q : pcnt_q + 16'd1);
            edge_d = edge_w;
            if (rise_w) begin
                seen_d = 1'b1;
                if (seen_q) begin
                    period_d = psat ? 16'hFFFF : pcnt_q + 16'd1;
                    pval_d   = 1'b1;
                end
            end
            if (tmo) begin
                err_d   = 1'b1;
                good_d  = '0;
                state_d = S_ACQ;
            end else if (edge_w) begin
                case (state_q)
                    S_ACQ: begin
                        good_d  = '0;
                        state_d = S_CHECK;
                    end
                    S_CHECK: begin
                        if (good_hl) begin
                            good_d = good_q + 8'd1;
                            if (good_q + 8'd1 == LOCK_N)
                                state_d = S_LOCKED;
                        end else begin
                            err_d  = 1'b1;
                            good_d = '0;
                        end
                    end
                    S_LOCKED: begin
                        if (!good_hl) begin
                            err_d   = 1'b1;
                            good_d  = '0;
                            state_d = S_CHECK;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            state_q  <= S_IDLE;
            hcnt_q   <= '0;
            pcnt_q   <= '0;
            good_q   <= '0;
            seen_q   <= 1'b0;
            edge_q   <= 1'b0;
            period_q <= '0;
            pval_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_q     <= i_clk_div;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            pcnt_q   <= pcnt_d;
            good_q   <= good_d;
            seen_q   <= seen_d;
            edge_q   <= edge_d;
            period_q <= period_d;
            pval_q   <= pval_d;
            err_q    <= err_d;
        end
    end

    assign o_edge         = edge_q;
    assign o_period       = period_q;
    assign o_period_valid = pval_q;
    assign o_locked       = (state_q == S_LOCKED);
    assign o_err          = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: cycle table on a divide-by-4 instance,
// plus a fast divide-by-2 sequence on a second instance.
module tb_clk_div_monitor;

    typedef struct {
        logic        rst;
        logic        en;
        logic        d;
        logic        e;
        logic        v;
        logic        l;
        logic        er;
        logic [15:0] p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0, en = 1'b0, d = 1'b0;
    logic        rst2 = 1'b0, en2 = 1'b0, d2 = 1'b0;
    logic        o_edge, o_pv, o_locked, o_err;
    logic [15:0] o_period;
    logic        f_edge, f_pv, f_locked, f_err;
    logic [15:0] f_period;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    clk_div_monitor #(
        .P_CLK_DIV_CNT(4),
        .P_LOCK_CNT   (4),
        .P_TOL        (0)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_clk_div     (d),
        .o_edge        (o_edge),
        .o_period      (o_period),
        .o_period_valid(o_pv),
        .o_locked      (o_locked),
        .o_err         (o_err)
    );

    clk_div_monitor #(
        .P_CLK_DIV_CNT(2),
        .P_LOCK_CNT   (4),
        .P_TOL        (0)
    ) dut_fast (
        .i_clk         (clk),
        .i_rst         (rst2),
        .i_en          (en2),
        .i_clk_div     (d2),
        .o_edge        (f_edge),
        .o_period      (f_period),
        .o_period_valid(f_pv),
        .o_locked      (f_locked),
        .o_err         (f_err)
    );

    task automatic add(input logic r, input logic e_n, input logic dv,
                       input logic xe, input logic xv, input logic xl,
                       input logic xer, input logic [15:0] xp);
        vec_t t;
        t.rst = r;  t.en = e_n; t.d = dv;
        t.e = xe;   t.v = xv;   t.l = xl;
        t.er = xer; t.p = xp;
        tv.push_back(t);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [19:0] act, input logic [19:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got edge/pv/lock/err=%b period=%0d, need %b period=%0d",
                     name, idx, act[19:16], act[15:0], exp[19:16], exp[15:0]);
        end
    endtask

    initial begin
        // reset held with input toggling, then released with enable low
        add(0,0,0, 0,0,0,0,0); add(0,0,1, 0,0,0,0,0);
        add(0,0,0, 0,0,0,0,0); add(1,0,0, 0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0);
        // ideal lock: toggle every 2 clocks
        add(1,1,0, 0,0,0,0,0); add(1,1,1, 0,0,0,0,0);
        add(1,1,1, 0,0,0,0,0); add(1,1,0, 1,0,0,0,0);
        add(1,1,0, 0,0,0,0,0); add(1,1,1, 1,0,0,0,0);
        add(1,1,1, 0,0,0,0,0); add(1,1,0, 1,1,0,0,4);
        add(1,1,0, 0,0,0,0,4); add(1,1,1, 1,0,0,0,4);
        add(1,1,1, 0,0,0,0,4); add(1,1,0, 1,1,1,0,4);
        add(1,1,0, 0,0,1,0,4); add(1,1,1, 1,0,1,0,4);
        add(1,1,1, 0,0,1,0,4); add(1,1,0, 1,1,1,0,4);
        add(1,1,0, 0,0,1,0,4);
        // one low half stretched to 3 clocks
        add(1,1,0, 1,0,1,0,4); add(1,1,1, 0,0,1,0,4);
        add(1,1,1, 0,0,1,0,4); add(1,1,0, 1,1,0,1,5);
        add(1,1,0, 0,0,0,0,5); add(1,1,1, 1,0,0,0,5);
        add(1,1,1, 0,0,0,0,5); add(1,1,0, 1,1,0,0,4);
        add(1,1,0, 0,0,0,0,4); add(1,1,1, 1,0,0,0,4);
        add(1,1,1, 0,0,0,0,4); add(1,1,0, 1,1,1,0,4);
        add(1,1,0, 0,0,1,0,4); add(1,1,1, 1,0,1,0,4);
        // input stuck high -> timeout
        add(1,1,1, 0,0,1,0,4); add(1,1,1, 1,1,1,0,4);
        add(1,1,1, 0,0,1,0,4); add(1,1,1, 0,0,1,0,4);
        add(1,1,1, 0,0,0,1,4); add(1,1,1, 0,0,0,0,4);
        add(1,1,1, 0,0,0,0,4);
        // resume toggling, reacquire and relock
        add(1,1,0, 0,0,0,0,4); add(1,1,0, 0,0,0,0,4);
        add(1,1,1, 1,0,0,0,4); add(1,1,1, 0,0,0,0,4);
        add(1,1,0, 1,1,0,0,10); add(1,1,0, 0,0,0,0,10);
        add(1,1,1, 1,0,0,0,10); add(1,1,1, 0,0,0,0,10);
        add(1,1,0, 1,1,0,0,4); add(1,1,0, 0,0,0,0,4);
        add(1,1,1, 1,0,1,0,4); add(1,1,1, 0,0,1,0,4);
        add(1,1,0, 1,1,1,0,4);
        // enable dropped while locked; period holds
        add(1,0,0, 0,0,0,0,4); add(1,0,1, 0,0,0,0,4);
        add(1,0,1, 0,0,0,0,4); add(1,0,0, 0,0,0,0,4);
        // re-enable, first rise after enable gives no period pulse
        add(1,1,0, 0,0,0,0,4); add(1,1,1, 1,0,0,0,4);
        add(1,1,1, 0,0,0,0,4); add(1,1,0, 1,0,0,0,4);
        add(1,1,0, 0,0,0,0,4); add(1,1,1, 1,0,0,0,4);
        add(1,1,1, 0,0,0,0,4); add(1,1,0, 1,1,0,0,4);
        add(1,1,0, 0,0,0,0,4); add(1,1,1, 1,0,1,0,4);
        add(1,1,1, 0,0,1,0,4); add(1,1,0, 1,1,1,0,4);
        add(1,1,0, 0,0,1,0,4); add(1,1,1, 1,0,1,0,4);
        add(1,1,1, 0,0,1,0,4);
        // reset while locked, coinciding with an edge and i_en high
        add(0,1,0, 0,0,0,0,0); add(1,0,0, 0,0,0,0,0);

        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].rst;
            en  = tv[i].en;
            d   = tv[i].d;
            @(posedge clk);
            #1;
            check("tbl", i + 1,
                  {o_edge, o_pv, o_locked, o_err, o_period},
                  {tv[i].e, tv[i].v, tv[i].l, tv[i].er, tv[i].p});
        end

        // fast ratio: divide-by-2, input toggles every clock
        rst2 = 1'b0; en2 = 1'b0; d2 = 1'b0;
        @(posedge clk);
        #1;
        check("fast_rst", 0,
              {f_edge, f_pv, f_locked, f_err, f_period}, 20'd0);
        for (int j = 1; j <= 12; j++) begin
            logic        xe, xv, xl;
            logic [15:0] xp;
            rst2 = 1'b1; en2 = 1'b1; d2 = j[0];
            @(posedge clk);
            #1;
            xe = (j >= 3);
            xl = (j >= 7);
            xv = (j >= 5) && j[0];
            xp = (j >= 5) ? 16'd2 : 16'd0;
            check("fast", j,
                  {f_edge, f_pv, f_locked, f_err, f_period},
                  {xe, xv, xl, 1'b0, xp});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
